// File: rtl/reset_sequencer.sv
// Central reset controller: merges masked reset requests into one stretched event,
// releases domain resets in a staggered order, then waits for the init-done acknowledge.
module reset_sequencer #(
  parameter int NREQ        = 4,
  parameter int NDOM        = 3,
  parameter int STRETCH     = 16,
  parameter int STAGE_GAP   = 8,
  parameter int ACK_TIMEOUT = 1024,
  parameter int TW          = 16,
  parameter int CNTW        = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NREQ-1:0] req_i,
  input  logic [NREQ-1:0] req_mask_i,
  input  logic            ack_i,
  output logic [NDOM-1:0] rst_o,
  output logic            busy_o,
  output logic [NREQ-1:0] cause_o,
  output logic [CNTW-1:0] count_o
);

  localparam int SW = (NDOM > 1) ? $clog2(NDOM) : 1;
  localparam logic [TW-1:0] STRETCH_TC = TW'(STRETCH - 1);
  localparam logic [TW-1:0] GAP_TC     = TW'(STAGE_GAP - 1);
  localparam logic [TW-1:0] ACK_TC     = TW'(ACK_TIMEOUT - 1);
  localparam logic [SW-1:0] LAST_STAGE = SW'(NDOM - 1);

  typedef enum logic [2:0] {
    IDLE,
    ASSERT,
    RELEASE,
    WAIT_ACK,
    HOLDOFF
  } state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [SW-1:0]   stage;
  logic [NREQ-1:0] act;
  logic [NREQ-1:0] act_low;

  // Lowest set bit wins: two's-complement isolate.
  assign act     = req_i & req_mask_i;
  assign act_low = act & (~act + NREQ'(1));

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
    return (c == '1) ? c : c + CNTW'(1);
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= ASSERT;
      rst_o   <= '1;
      timer   <= '0;
      stage   <= '0;
      cause_o <= '0;
      count_o <= '0;
      busy_o  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (act != '0) begin
            rst_o   <= '1;
            cause_o <= act_low;
            count_o <= sat_inc(count_o);
            timer   <= '0;
            stage   <= '0;
            busy_o  <= 1'b1;
            state   <= ASSERT;
          end
        end
        ASSERT: begin
          if (timer == STRETCH_TC) begin
            rst_o[0] <= 1'b0;
            timer    <= '0;
            stage    <= SW'(1);
            state    <= (NDOM == 1) ? WAIT_ACK : RELEASE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        RELEASE: begin
          if (timer == GAP_TC) begin
            rst_o[stage] <= 1'b0;
            stage        <= stage + SW'(1);
            timer        <= '0;
            if (stage == LAST_STAGE) state <= WAIT_ACK;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        WAIT_ACK: begin
          // Acknowledge beats a timeout landing on the same edge.
          if (ack_i) begin
            state <= HOLDOFF;
          end else if ((ACK_TIMEOUT != 0) && (timer == ACK_TC)) begin
            rst_o   <= '1;
            timer   <= '0;
            stage   <= '0;
            count_o <= sat_inc(count_o);
            state   <= ASSERT;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        HOLDOFF: begin
          if (act == '0) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          rst_o  <= '1;
          timer  <= '0;
          stage  <= '0;
          busy_o <= 1'b1;
          state  <= ASSERT;
        end
      endcase
    end
  end

endmodule
